sseg_scan_reader: RTL and testbench
===================================

# sseg_scan_reader

Receive-side counterpart of the hex-to-seven-segment encoder: samples an externally driven, time-multiplexed seven-segment bus (segment lines plus digit enables), filters out scan transitions and ghosting, and decodes each digit's segment pattern back to a 4-bit hex value. It sits at an FPGA input boundary and lets logic or a test harness read what a display controller is showing. Decoded digits are held in registers until the next stable capture for that digit.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits / width of dig_en (1..8)
- STABLE_CYCLES, 16, consecutive cycles a synchronised bus value must hold before capture (>= 2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  7  segment lines, active-high, bit0=a … bit6=g
- dig_en  in  NUM_DIGITS  digit enables, active-high; bit i selects digit i
- digits_out  out  4*NUM_DIGITS  decoded nibbles, digit i in bits [4i+3:4i]
- digit_valid  out  NUM_DIGITS  bit i set when digits_out for digit i holds a legal decode
- update  out  1  one-cycle pulse on every capture (legal or illegal)
- err  out  1  sticky: an unrecognised pattern was captured
- clr_err  in  1  synchronous clear of err (level, sampled each cycle)

## Operation
- seg_in and dig_en pass through a 2-flop synchroniser as one vector; s1 = first stage, s2 = second.
- Stability filter: if s1 != s2 at an edge, cnt <= 0 and armed <= 1; else cnt increments, saturating at STABLE_CYCLES-1. cnt width = clog2(STABLE_CYCLES).
- Capture condition: armed && cnt == STABLE_CYCLES-1 && dig_en part of s2 is exactly one-hot. On capture: armed <= 0, update <= 1 next cycle, digit i selected by one-hot index.
- Zero or multi-hot dig_en at the capture point: no capture, armed <= 0, no update, no state change (blanking and overlap are ignored).
- Decode table (g..a): 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9, 1110111=A, 1111100=B, 0111001=C, 1011110=D, 1111001=E, 1110001=F.
- Legal pattern: nibble written to digit i, digit_valid[i] <= 1.
- Any other pattern (including 0000000): nibble for digit i unchanged, digit_valid[i] <= 0, err <= 1.
- err: set has priority over clr_err in the same cycle.
- A held value is captured once only; re-capture requires a change then STABLE_CYCLES of stability.

## Timing
- Reset (async assert, sync release irrelevant to outputs): digits_out = 0, digit_valid = 0, update = 0, err = 0, s1 = s2 = 0, cnt = 0, armed = 0.
- Latency: new bus value present before edge k → s1 at k, s2 at k+1 (cnt cleared), cnt = STABLE_CYCLES-1 after edge k+STABLE_CYCLES, digits_out/digit_valid/update registered at edge k+STABLE_CYCLES+1 (edge k+17 with default).
- update high for exactly one cycle per capture; digits_out and digit_valid change only in that same cycle.
- Glitch shorter than STABLE_CYCLES (after synchronisation) restarts the count; no capture of the glitch or of the interrupted value until it re-stabilises.
- Reset mid-count: all state cleared immediately; value present after release is treated as a change from 0.
- Minimum per-digit scan dwell for reliable reads: STABLE_CYCLES+2 cycles.

## Test plan
- Reset, then dig_en=0001, seg_in=1011011 held 30 cycles → update single pulse at edge k+17, digits_out[3:0]=2, digit_valid=0001, err=0.
- Scan 4 digits, 40 cycles each, patterns for 3,A,0,F on digits 0..3 → digits_out=16'hF0A3, digit_valid=1111, exactly 4 update pulses per scan.
- dig_en=0010, seg_in=1111111 held 10 cycles then changed to 0000110 for 30 cycles → no capture of 8; digit 1 = 1, one update pulse.
- dig_en=0110 or 0000 held 50 cycles with valid pattern → no update, outputs unchanged.
- Digit 2 valid holding 5, then seg_in=0101010 held 30 cycles → digit_valid[2]=0, nibble still 5, err=1; clr_err pulsed → err=0; clr_err coincident with a new illegal capture → err stays 1.
- rst_n low for 1 cycle mid-count (cnt=8) → all outputs 0 immediately, no update until value re-stabilises 17 edges after release.

Source files
------------

// File: rtl/sseg_scan_reader.sv
// Samples a multiplexed seven-segment bus, waits for it to settle, and decodes
// each scanned digit back to a hex nibble held per digit until its next capture.
module sseg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    err,
    input  logic                    clr_err
);

    localparam int BW = 7 + NUM_DIGITS;
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [BW-1:0]           s1_q, s2_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic                    err_q, err_d;

    logic                    changed;
    logic [6:0]              seg_s;
    logic [NUM_DIGITS-1:0]   dig_s;
    logic                    one_hot;
    logic                    at_point;
    logic                    capture;
    logic [4:0]              dec;

    // Returns {legal, nibble}; pattern bits are g..a.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0111111: r = {1'b1, 4'h0};
            7'b0000110: r = {1'b1, 4'h1};
            7'b1011011: r = {1'b1, 4'h2};
            7'b1001111: r = {1'b1, 4'h3};
            7'b1100110: r = {1'b1, 4'h4};
            7'b1101101: r = {1'b1, 4'h5};
            7'b1111101: r = {1'b1, 4'h6};
            7'b0000111: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1101111: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b1111100: r = {1'b1, 4'hB};
            7'b0111001: r = {1'b1, 4'hC};
            7'b1011110: r = {1'b1, 4'hD};
            7'b1111001: r = {1'b1, 4'hE};
            7'b1110001: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    always_comb begin
        changed  = (s1_q != s2_q);
        seg_s    = s2_q[6:0];
        dig_s    = s2_q[BW-1:7];
        one_hot  = (dig_s != '0) && ((dig_s & (dig_s - NUM_DIGITS'(1))) == '0);
        at_point = armed_q && (cnt_q == CNT_MAX);
        capture  = at_point && one_hot;
        dec      = decode(seg_s);

        cnt_d = cnt_q;
        if (changed)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);

        // A fresh change re-arms even if the previous value is captured on this edge.
        armed_d = armed_q;
        if (changed)
            armed_d = 1'b1;
        else if (at_point)
            armed_d = 1'b0;

        digits_d = digits_q;
        valid_d  = valid_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && dig_s[i]) begin
                if (dec[4]) begin
                    digits_d[4*i +: 4] = dec[3:0];
                    valid_d[i]         = 1'b1;
                end else begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        update_d = capture;

        err_d = err_q;
        if (capture && !dec[4])
            err_d = 1'b1;
        else if (clr_err)
            err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            digits_q <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= {dig_en, seg_in};
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Directed bench for sseg_scan_reader: drives bus patterns on the falling edge
// and checks capture timing, decoded nibbles, validity and the sticky error.
module tb_sseg_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        update;
    logic        err;
    logic        clr_err;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_n = 0;
    int upd_cnt = 0;
    int last_upd = -1;
    int k;

    sseg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_en     (dig_en),
        .digits_out (digits_out),
        .digit_valid(digit_valid),
        .update     (update),
        .err        (err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        if (update === 1'b1) begin
            upd_cnt++;
            last_upd = edge_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drives a bus value at a falling edge, returns the edge that first samples it.
    task automatic drive(input logic [6:0] seg, input logic [3:0] dig, output int k_o);
        @(negedge clk);
        seg_in = seg;
        dig_en = dig;
        k_o    = edge_n + 1;
    endtask

    task automatic hold(input logic [6:0] seg, input logic [3:0] dig, input int n, output int k_o);
        drive(seg, dig, k_o);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        seg_in  = '0;
        dig_en  = '0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_digits", digits_out, 16'h0000);
        chk("rst_valid", digit_valid, 4'h0);
        chk("rst_update", update, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single digit capture and its latency
        upd_cnt = 0;
        hold(7'b1011011, 4'b0001, 30, k);
        chk("t1_upd_cnt", upd_cnt, 1);
        chk("t1_upd_edge", last_upd, k + 17);
        chk("t1_digit0", digits_out[3:0], 4'h2);
        chk("t1_valid", digit_valid, 4'b0001);
        chk("t1_err", err, 1'b0);

        // Full scan of four digits
        upd_cnt = 0;
        hold(7'b1001111, 4'b0001, 40, k);
        hold(7'b1110111, 4'b0010, 40, k);
        hold(7'b0111111, 4'b0100, 40, k);
        hold(7'b1110001, 4'b1000, 40, k);
        chk("t2_upd_cnt", upd_cnt, 4);
        chk("t2_digits", digits_out, 16'hF0A3);
        chk("t2_valid", digit_valid, 4'hF);

        // Short-lived 8 is never captured, the settled 1 is
        upd_cnt = 0;
        hold(7'b1111111, 4'b0010, 10, k);
        hold(7'b0000110, 4'b0010, 30, k);
        chk("t3_upd_cnt", upd_cnt, 1);
        chk("t3_digits", digits_out, 16'hF013);
        chk("t3_upd_edge", last_upd, k + 17);

        // Overlapping and blanked enables are ignored
        upd_cnt = 0;
        hold(7'b1101101, 4'b0110, 50, k);
        hold(7'b1101101, 4'b0000, 50, k);
        chk("t4_upd_cnt", upd_cnt, 0);
        chk("t4_digits", digits_out, 16'hF013);
        chk("t4_valid", digit_valid, 4'hF);

        // Illegal pattern keeps the nibble, drops valid, sets err
        upd_cnt = 0;
        hold(7'b1101101, 4'b0100, 30, k);
        chk("t5_digits5", digits_out, 16'hF513);
        hold(7'b0101010, 4'b0100, 30, k);
        chk("t5_valid", digit_valid, 4'b1011);
        chk("t5_digits", digits_out, 16'hF513);
        chk("t5_err", err, 1'b1);
        chk("t5_upd_cnt", upd_cnt, 2);

        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        chk("t5_clr", err, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        chk("t5_no_recapture_err", err, 1'b0);
        chk("t5_no_recapture_upd", upd_cnt, 2);

        // Clear coinciding with an illegal capture: set wins
        drive(7'b0000000, 4'b0100, k);
        repeat (17) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        chk("t5_coinc_edge", last_upd, k + 17);
        chk("t5_coinc_err", err, 1'b1);
        @(negedge clk);
        #1;
        chk("t5_err_held", err, 1'b1);

        // Reset in the middle of a count
        hold(7'b0000111, 4'b0001, 10, k);
        rst_n = 1'b0;
        #1;
        upd_cnt = 0;
        chk("t6_rst_digits", digits_out, 16'h0000);
        chk("t6_rst_valid", digit_valid, 4'h0);
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_update", update, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        k = edge_n + 1;
        repeat (30) @(negedge clk);
        #1;
        chk("t6_upd_cnt", upd_cnt, 1);
        chk("t6_upd_edge", last_upd, k + 17);
        chk("t6_digit0", digits_out, 16'h0007);
        chk("t6_valid", digit_valid, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
